serial_sub_ctrl: RTL

Bit-serial N-bit subtractor controller. It sequences a single 1-bit full-subtractor cell, built from two half-subtractor stages plus a borrow OR, over WIDTH clock cycles to compute a − b. The block sits alongside the gate-level arithmetic circuits as the first sequential consumer of the subtractor cells. It provides a start/busy/done handshake for a host.

---
 rtl/serial_sub_ctrl_pkg.sv | 13 +
 rtl/serial_sub_ctrl_full_sub_bit.sv | 44 ++++
 rtl/serial_sub_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// FSM state encodings and the default operand width.
package serial_sub_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_ctrl_full_sub_bit.sv
// One-bit full subtractor built from two half subtractors and an OR of their borrows.
// Purely combinational; the controller registers everything around it.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic bo1;
  logic bo2;

  half_sub u_hs0 (
    .x  (a),
    .y  (b),
    .d  (d1),
    .bo (bo1)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_sub u_hs1 (
    .x  (d1),
    .y  (bin),
    .d  (d),
    .bo (bo2)
  );

  assign bout = bo1 | bo2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b over WIDTH cycles using one full_sub_bit cell, LSB first.
// start/busy/done handshake; diff/borr are registered and held until the next accepted start.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borr_q, borr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             d_bit;
  logic             bout_bit;

  full_sub_bit u_bit (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bin_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= 1'b0;
      borr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      borr_q  <= borr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    borr_d  = borr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new start directly so back-to-back operations lose no cycle.
        if (start) begin
          state_d = ST_SHIFT;
          a_d     = a;
          b_d     = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = d_bit;
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        bin_d            = bout_bit;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          borr_d  = bout_bit;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = res_q;
  assign borr = borr_q;

endmodule
